// File: rtl/bp_perf_monitor.sv
// bp_perf_monitor: saturating branch/miss/instruction counters, windowed snapshots and a miss-PC log FIFO.
module bp_perf_monitor #(
  parameter int CNT_WIDTH = 32,
  parameter int LOG_DEPTH = 8,
  parameter int WINDOW    = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 br_instr_i,
  input  logic                 br_misses_i,
  input  logic [31:0]          instr_i,
  input  logic [31:0]          t_instr_i,
  output logic [CNT_WIDTH-1:0] cyc_cnt_o,
  output logic [CNT_WIDTH-1:0] instr_cnt_o,
  output logic [CNT_WIDTH-1:0] br_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o,
  output logic                 win_vld_o,
  output logic [CNT_WIDTH-1:0] win_br_o,
  output logic [CNT_WIDTH-1:0] win_miss_o,
  output logic                 log_vld_o,
  output logic [31:0]          log_pc_o,
  input  logic                 log_rdy_i,
  output logic                 log_ovf_o
);
  localparam int PW = $clog2(LOG_DEPTH);
  localparam int WW = $clog2(WINDOW);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  state_e state_q, state_d;
  cnt_t cyc_q, cyc_d, instr_q, instr_d, br_q, br_d, miss_q, miss_d;
  cnt_t acc_br_q, acc_br_d, acc_miss_q, acc_miss_d, win_br_q, win_br_d, win_miss_q, win_miss_d;
  cnt_t acc_br_inc, acc_miss_inc;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic win_vld_q, win_vld_d, ovf_q, ovf_d;
  logic [31:0] mem_q [LOG_DEPTH];
  logic [31:0] mem_d [LOG_DEPTH];
  logic [31:0] log_pc_q, log_pc_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] occ_q, occ_d;
  logic run, br, miss, useful, win_close, full, pop, push;
  function automatic cnt_t sat_inc(input cnt_t c, input logic inc);
    return (inc && c != '1) ? c + 1'b1 : c;
  endfunction
  always_comb begin
    run          = state_q == RUN;
    br           = run && br_instr_i;
    miss         = br && br_misses_i;
    useful       = run && instr_i != 32'h0000_0000 && instr_i != 32'h0000_0013;
    win_close    = run && win_cnt_q == WW'(WINDOW - 1);
    state_d      = (state_q == IDLE && !en_i) ? IDLE : (en_i ? RUN : HALT);
    cyc_d        = sat_inc(cyc_q, run);
    instr_d      = sat_inc(instr_q, useful);
    br_d         = sat_inc(br_q, br);
    miss_d       = sat_inc(miss_q, miss);
    acc_br_inc   = sat_inc(acc_br_q, br);
    acc_miss_inc = sat_inc(acc_miss_q, miss);
    acc_br_d     = win_close ? '0 : acc_br_inc;
    acc_miss_d   = win_close ? '0 : acc_miss_inc;
    win_br_d     = win_close ? acc_br_inc : win_br_q;
    win_miss_d   = win_close ? acc_miss_inc : win_miss_q;
    win_cnt_d    = win_close ? '0 : (run ? win_cnt_q + 1'b1 : win_cnt_q);
    win_vld_d    = win_close;
    full         = occ_q == (PW+1)'(LOG_DEPTH);
    pop          = !clr_i && occ_q != '0 && log_rdy_i;
    // a full FIFO still accepts a push when the head leaves the same cycle
    push         = miss && (!full || pop);
    ovf_d        = ovf_q || (miss && full && !pop);
    mem_d        = mem_q;
    if (push) mem_d[wr_q] = t_instr_i;
    wr_d         = wr_q + PW'(push);
    rd_d         = rd_q + PW'(pop);
    occ_d        = occ_q + (PW+1)'(push) - (PW+1)'(pop);
    log_pc_d     = mem_d[rd_d];
    if (clr_i) begin
      state_d    = IDLE;
      cyc_d      = '0;
      instr_d    = '0;
      br_d       = '0;
      miss_d     = '0;
      acc_br_d   = '0;
      acc_miss_d = '0;
      win_br_d   = '0;
      win_miss_d = '0;
      win_cnt_d  = '0;
      win_vld_d  = 1'b0;
      ovf_d      = 1'b0;
      wr_d       = '0;
      rd_d       = '0;
      occ_d      = '0;
      log_pc_d   = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      instr_q    <= '0;
      br_q       <= '0;
      miss_q     <= '0;
      acc_br_q   <= '0;
      acc_miss_q <= '0;
      win_br_q   <= '0;
      win_miss_q <= '0;
      win_cnt_q  <= '0;
      win_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
      log_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      instr_q    <= instr_d;
      br_q       <= br_d;
      miss_q     <= miss_d;
      acc_br_q   <= acc_br_d;
      acc_miss_q <= acc_miss_d;
      win_br_q   <= win_br_d;
      win_miss_q <= win_miss_d;
      win_cnt_q  <= win_cnt_d;
      win_vld_q  <= win_vld_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      occ_q      <= occ_d;
      log_pc_q   <= log_pc_d;
    end
  end
  assign cyc_cnt_o   = cyc_q;
  assign instr_cnt_o = instr_q;
  assign br_cnt_o    = br_q;
  assign miss_cnt_o  = miss_q;
  assign win_vld_o   = win_vld_q;
  assign win_br_o    = win_br_q;
  assign win_miss_o  = win_miss_q;
  assign log_vld_o   = occ_q != '0;
  assign log_pc_o    = log_pc_q;
  assign log_ovf_o   = ovf_q;
endmodule

// File: doc/bp_perf_monitor.md
# bp_perf_monitor

Branch-prediction performance monitor that sits directly downstream of the predictor-core testbench top. It consumes the per-cycle branch-instruction, misprediction, fetched-instruction and EX/MEM PC probes. It keeps saturating event counters and per-window branch/miss snapshots, and logs the PCs of mispredicted branches into a small FIFO. A bench or host drains that FIFO with a valid/ready handshake. It is used to compare the always-taken, two-bit, gshare and agree predictor variants without post-processing waveforms.

## Interface
- CNT_WIDTH, 32, width of every counter and snapshot
- LOG_DEPTH, 8, miss-log FIFO entries (power of two, ≥2)
- WINDOW, 1024, window length in RUN cycles (≥2)

- clk_i  in  1  clock
- rst_ni  in  1  one clock; reset is synchronous and active-low
- en_i  in  1  level: count while high
- clr_i  in  1  synchronous clear of counters, window and FIFO; priority over en_i
- br_instr_i  in  1  branch/jump resolved in EX/MEM this cycle
- br_misses_i  in  1  that branch was mispredicted (qualified by br_instr_i)
- instr_i  in  32  instruction in IF this cycle
- t_instr_i  in  32  EX/MEM PC of the resolving branch
- cyc_cnt_o  out  CNT_WIDTH  RUN cycles
- instr_cnt_o  out  CNT_WIDTH  useful fetched instructions
- br_cnt_o  out  CNT_WIDTH  branches
- miss_cnt_o  out  CNT_WIDTH  mispredictions
- win_vld_o  out  1  one-cycle pulse: window snapshot updated
- win_br_o  out  CNT_WIDTH  branches in last completed window
- win_miss_o  out  CNT_WIDTH  misses in last completed window
- log_vld_o  out  1  FIFO non-empty
- log_pc_o  out  32  PC at FIFO head
- log_rdy_i  in  1  pop when log_vld_o && log_rdy_i
- log_ovf_o  out  1  sticky: a miss was dropped because the FIFO was full

## Operation
- States:
  - IDLE (reset)
  - RUN
  - HALT
- Transitions:
  - IDLE→RUN when en_i=1.
  - RUN→HALT when en_i=0.
  - HALT→RUN when en_i=1.
  - clr_i=1 from any state → IDLE. All counters, window accumulators, snapshots, FIFO pointers and log_ovf_o clear the same edge.
- Events are sampled only in RUN. This includes the cycle in which en_i falls: the state is still RUN, so that cycle's events count.
- Counting rules in RUN:
  - cyc_cnt increments every cycle.
  - instr_cnt increments when instr_i ≠ 32'h0000_0000 and instr_i ≠ 32'h0000_0013 (bubble/NOP).
  - br_cnt increments on br_instr_i.
  - miss_cnt increments on br_instr_i && br_misses_i. br_misses_i without br_instr_i is ignored.
- All counters saturate at 2^CNT_WIDTH−1 and never wrap.
- Window:
  - A window cycle counter runs in RUN only; HALT freezes it.
  - In the RUN cycle where it equals WINDOW−1:
    - win_br_o/win_miss_o load accumulator-plus-current-event.
    - The accumulators and window counter reset to 0.
    - win_vld_o pulses.
  - Window accumulators saturate the same way as the main counters.
- Miss log:
  - Push t_instr_i when RUN && br_instr_i && br_misses_i.
  - Pop when log_vld_o && log_rdy_i; this is allowed in any state except the clr_i cycle.
  - Push while full with no pop in the same cycle: the entry is dropped and log_ovf_o sets.
  - Push and pop in the same cycle while full: both take effect, no overflow.
  - Push and pop in the same cycle while empty: the push takes effect and the pop is ignored, since log_vld_o is 0.
  - Pointers wrap modulo LOG_DEPTH. An occupancy count of log2(LOG_DEPTH)+1 bits distinguishes full from empty.

## Timing
- Reset values: all counters, snapshots and log_pc_o are 0; win_vld_o, log_vld_o and log_ovf_o are 0; state is IDLE.
- All outputs are registered. An event at edge k is reflected on the counter outputs after edge k, i.e. one cycle of latency.
- win_vld_o is high for exactly the cycle after the closing edge, coincident with the new snapshot values.
- The first push into an empty FIFO makes log_vld_o=1 after that edge.
- log_pc_o is stable while log_vld_o=1 and log_rdy_i=0.
- After a pop, the next entry appears the following cycle. FIFO throughput is one pop per cycle.
- clr_i asserted together with an event: the clear wins and the event is lost.
- rst_ni low mid-operation behaves like clr_i and also forces IDLE.

## Test plan
- Reset then en_i=1 for 10 cycles with no events → cyc_cnt_o=10; instr_cnt_o, br_cnt_o and miss_cnt_o = 0; log_vld_o=0.
- RUN, drive 5 branches with 2 misses (PCs 0x100, 0x2A4), log_rdy_i=0 → br_cnt_o=5, miss_cnt_o=2; log_pc_o=0x100; after one pop log_pc_o=0x2A4; after a second pop log_vld_o=0.
- LOG_DEPTH=8: 9 misses with no pops → 8 entries held, log_ovf_o=1, first entry retained. On a 10th miss issued together with a pop, it is accepted and log_ovf_o stays 1.
- WINDOW=16: 3 branches / 1 miss in the first 16 RUN cycles → win_vld_o pulses once at cycle 17 with win_br_o=3, win_miss_o=1. A branch on the closing cycle counts in that window.
- en_i low for 5 cycles mid-window → counters and window counter frozen, pop still works; with en_i high again the window closes 5 cycles later.
- CNT_WIDTH=4: 20 branches → br_cnt_o holds at 15. clr_i asserted together with br_instr_i → all counters 0, log_ovf_o=0, state IDLE.
